neuron_train_sequencer: RTL and testbench

Synthesizable training controller for the two-input neuron datapath. It iterates over an on-chip sample store by address, steps one shared multiply/accumulate path through bias and weight terms, and applies a weight update whenever the datapath reports a sign mismatch. It counts epochs and stops either when an epoch completes with no mismatches or when the epoch limit is reached.

---
 rtl/neuron_pkg.sv | 40 ++++
 rtl/neuron_train_counter.sv | 72 +++++++
 rtl/neuron_train_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_neuron_train_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared definitions for the two-input neuron training block:
//               controller state encoding, datapath term-select encodings
//               and default widths/limits.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Default sizing of the training controller.
    localparam int DEF_N_SAMPLES  = 4;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_MAX_EPOCHS = 16;
    localparam int DEF_EPOCH_W    = 5;

    // Term selected onto the shared multiply/accumulate path.
    // Encoding 3 is unused.
    localparam logic [1:0] SEL_B  = 2'd0;  // bias term (x = 1)
    localparam logic [1:0] SEL_W1 = 2'd1;  // w1 * x1
    localparam logic [1:0] SEL_W2 = 2'd2;  // w2 * x2

    // Training controller states.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_ACC_B     = 4'd2,
        S_ACC_W1    = 4'd3,
        S_ACC_W2    = 4'd4,
        S_CHECK     = 4'd5,
        S_UPD_B     = 4'd6,
        S_UPD_W1    = 4'd7,
        S_UPD_W2    = 4'd8,
        S_NEXT      = 4'd9,
        S_EPOCH_END = 4'd10,
        S_FINISH    = 4'd11
    } state_t;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/neuron_train_counter.sv
`default_nettype none
// ============================================================================
// Module      : neuron_train_counter
// Description : Sample-address and epoch counters for the training
//               controller. Clear has priority over increment. The address
//               counter saturates at N_SAMPLES-1 so it can never index past
//               the sample store.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_addr_clr/inc    - sample address clear / increment
//               i_epoch_clr/inc   - epoch counter clear / increment
//               o_addr, o_epoch   - current counter values
//               o_addr_last       - address is the last sample of an epoch
//               o_epoch_last      - one more epoch reaches MAX_EPOCHS
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_train_counter
    import neuron_pkg::*;
#(
    parameter int N_SAMPLES  = DEF_N_SAMPLES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_EPOCHS = DEF_MAX_EPOCHS,
    parameter int EPOCH_W    = DEF_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_addr_clr,
    input  logic               i_addr_inc,
    input  logic               i_epoch_clr,
    input  logic               i_epoch_inc,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [EPOCH_W-1:0] o_epoch,
    output logic               o_addr_last,
    output logic               o_epoch_last
);

    localparam logic [ADDR_W-1:0]  c_ADDR_LAST  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] c_EPOCH_LAST = EPOCH_W'(MAX_EPOCHS - 1);

    logic [ADDR_W-1:0]  r_addr;
    logic [EPOCH_W-1:0] r_epoch;
    logic               w_addr_last;

    assign w_addr_last = (r_addr == c_ADDR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_addr_clr) begin
            r_addr <= '0;
        end else if (i_addr_inc && !w_addr_last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_epoch <= '0;
        end else if (i_epoch_clr) begin
            r_epoch <= '0;
        end else if (i_epoch_inc) begin
            r_epoch <= r_epoch + 1'b1;
        end
    end

    assign o_addr       = r_addr;
    assign o_epoch      = r_epoch;
    assign o_addr_last  = w_addr_last;
    // epoch + 1 == MAX_EPOCHS, evaluated before the increment lands
    assign o_epoch_last = (r_epoch == c_EPOCH_LAST);

endmodule : neuron_train_counter
`default_nettype wire

// File: rtl/neuron_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_train_sequencer
// Description : Training controller for the two-input neuron datapath.
//               Walks the sample store by address; for each sample it
//               accumulates bias, w1*x1 and w2*x2 into y_in, checks the
//               datapath's sign-mismatch flag and, on mismatch, issues the
//               bias/w1/w2 update strobes. Stops when an epoch is
//               mismatch-free or the epoch limit is reached.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               start        - begin training (sampled in IDLE only)
//               mismatch     - datapath sign mismatch (sampled in CHECK only)
//               addr         - sample store index
//               init_regs    - clear b/w1/w2
//               acc_clr      - y_in loads instead of accumulating
//               sel_term     - term select (SEL_B/SEL_W1/SEL_W2)
//               ld_yin       - y_in load strobe
//               ld_b/w1/w2   - weight update strobes
//               ready        - idle, accepting start
//               done         - one-cycle end-of-training pulse
//               converged    - last run ended on an error-free epoch
//               epoch        - epochs completed in current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_train_sequencer
    import neuron_pkg::*;
#(
    parameter int N_SAMPLES  = DEF_N_SAMPLES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_EPOCHS = DEF_MAX_EPOCHS,
    parameter int EPOCH_W    = DEF_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mismatch,
    output logic [ADDR_W-1:0]  addr,
    output logic               init_regs,
    output logic               acc_clr,
    output logic [1:0]         sel_term,
    output logic               ld_yin,
    output logic               ld_b,
    output logic               ld_w1,
    output logic               ld_w2,
    output logic               ready,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch
);

    state_t r_state;
    state_t w_state_nxt;

    logic r_err_flag;
    logic r_converged;

    logic w_addr_clr;
    logic w_addr_inc;
    logic w_epoch_clr;
    logic w_epoch_inc;
    logic w_addr_last;
    logic w_epoch_last;
    logic w_err_set;
    logic w_err_clr;
    logic w_conv_set;
    logic w_conv_clr;

    neuron_train_counter #(
        .N_SAMPLES  (N_SAMPLES),
        .ADDR_W     (ADDR_W),
        .MAX_EPOCHS (MAX_EPOCHS),
        .EPOCH_W    (EPOCH_W)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_addr_clr   (w_addr_clr),
        .i_addr_inc   (w_addr_inc),
        .i_epoch_clr  (w_epoch_clr),
        .i_epoch_inc  (w_epoch_inc),
        .o_addr       (addr),
        .o_epoch      (epoch),
        .o_addr_last  (w_addr_last),
        .o_epoch_last (w_epoch_last)
    );

    // State register. Reset abandons any in-flight update sequence; the
    // datapath registers are left alone until the next INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_nxt = r_state;
        init_regs   = 1'b0;
        acc_clr     = 1'b0;
        sel_term    = SEL_B;
        ld_yin      = 1'b0;
        ld_b        = 1'b0;
        ld_w1       = 1'b0;
        ld_w2       = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        w_addr_clr  = 1'b0;
        w_addr_inc  = 1'b0;
        w_epoch_clr = 1'b0;
        w_epoch_inc = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_conv_set  = 1'b0;
        w_conv_clr  = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                init_regs   = 1'b1;
                w_addr_clr  = 1'b1;
                w_epoch_clr = 1'b1;
                w_err_clr   = 1'b1;
                w_conv_clr  = 1'b1;
                w_state_nxt = S_ACC_B;
            end
            S_ACC_B: begin
                acc_clr     = 1'b1;
                sel_term    = SEL_B;
                ld_yin      = 1'b1;
                w_state_nxt = S_ACC_W1;
            end
            S_ACC_W1: begin
                sel_term    = SEL_W1;
                ld_yin      = 1'b1;
                w_state_nxt = S_ACC_W2;
            end
            S_ACC_W2: begin
                sel_term    = SEL_W2;
                ld_yin      = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_UPD_B;
                end else begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_UPD_B: begin
                ld_b        = 1'b1;
                w_state_nxt = S_UPD_W1;
            end
            S_UPD_W1: begin
                ld_w1       = 1'b1;
                w_state_nxt = S_UPD_W2;
            end
            S_UPD_W2: begin
                ld_w2       = 1'b1;
                w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_addr_last) begin
                    w_state_nxt = S_EPOCH_END;
                end else begin
                    w_addr_inc  = 1'b1;
                    w_state_nxt = S_ACC_B;
                end
            end
            S_EPOCH_END: begin
                w_epoch_inc = 1'b1;
                if (!r_err_flag) begin
                    w_conv_set  = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (w_epoch_last) begin
                    w_conv_clr  = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_err_clr   = 1'b1;
                    w_addr_clr  = 1'b1;
                    w_state_nxt = S_ACC_B;
                end
            end
            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-epoch error flag and sticky convergence result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_flag  <= 1'b0;
            r_converged <= 1'b0;
        end else begin
            if (w_err_clr) begin
                r_err_flag <= 1'b0;
            end else if (w_err_set) begin
                r_err_flag <= 1'b1;
            end
            if (w_conv_clr) begin
                r_converged <= 1'b0;
            end else if (w_conv_set) begin
                r_converged <= 1'b1;
            end
        end
    end

    assign converged = r_converged;

endmodule : neuron_train_sequencer
`default_nettype wire

// File: tb/tb_neuron_train_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_neuron_train_sequencer
// Description : Scoreboard bench for neuron_train_sequencer. A mismatch table
//               indexed by (epoch, addr) plays the datapath; a run-level model
//               predicts latency, result and strobe counts per run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_train_sequencer;
    import neuron_pkg::*;

    localparam int N_SAMPLES  = 4;
    localparam int ADDR_W     = 2;
    localparam int MAX_EPOCHS = 5;
    localparam int EPOCH_W    = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               mismatch;
    logic [ADDR_W-1:0]  addr;
    logic               init_regs;
    logic               acc_clr;
    logic [1:0]         sel_term;
    logic               ld_yin;
    logic               ld_b;
    logic               ld_w1;
    logic               ld_w2;
    logic               ready;
    logic               done;
    logic               converged;
    logic [EPOCH_W-1:0] epoch;

    neuron_train_sequencer #(
        .N_SAMPLES  (N_SAMPLES),
        .ADDR_W     (ADDR_W),
        .MAX_EPOCHS (MAX_EPOCHS),
        .EPOCH_W    (EPOCH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mismatch  (mismatch),
        .addr      (addr),
        .init_regs (init_regs),
        .acc_clr   (acc_clr),
        .sel_term  (sel_term),
        .ld_yin    (ld_yin),
        .ld_b      (ld_b),
        .ld_w1     (ld_w1),
        .ld_w2     (ld_w2),
        .ready     (ready),
        .done      (done),
        .converged (converged),
        .epoch     (epoch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: mismatch outcome per (epoch, sample).
    bit tbl [MAX_EPOCHS][N_SAMPLES];
    assign mismatch = (int'(epoch) < MAX_EPOCHS) ? tbl[int'(epoch)][int'(addr)] : 1'b0;

    typedef struct {
        int lat;     // cycles from INIT to done
        int conv;
        int epochs;
        int n_smp;   // samples processed
        int n_upd;   // update bursts
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Run-level reference: walk epochs and samples using the training rules.
    function automatic exp_t model();
        exp_t e;
        int   sum;
        bit   err;
        e.n_smp = 0;
        e.n_upd = 0;
        e.conv  = 0;
        sum     = 0;
        e.epochs = 0;
        forever begin
            err = 1'b0;
            for (int a = 0; a < N_SAMPLES; a++) begin
                e.n_smp++;
                if (tbl[e.epochs][a]) begin
                    sum += 8;
                    e.n_upd++;
                    err = 1'b1;
                end else begin
                    sum += 5;
                end
            end
            e.epochs++;
            if (!err) begin
                e.conv = 1;
                break;
            end
            if (e.epochs == MAX_EPOCHS) break;
        end
        e.lat = sum + e.epochs + 1;
        return e;
    endfunction

    // mode 0: all clean, 1: all mismatch, 2: random with density num/8
    task automatic fill(input int mode, input int num);
        for (int ep = 0; ep < MAX_EPOCHS; ep++)
            for (int a = 0; a < N_SAMPLES; a++)
                case (mode)
                    0:       tbl[ep][a] = 1'b0;
                    1:       tbl[ep][a] = 1'b1;
                    default: tbl[ep][a] = ($urandom_range(0, 7) < num);
                endcase
    endtask

    // Monitor: accumulates per-run observations, scores against the queue on done.
    initial begin : monitor
        exp_t e;
        int   init_cyc, n_yin, n_clr, n_b, n_w1, n_w2, bad_seq, bad_addr, phase;
        bit   p_b, p_w1;
        init_cyc = 0; n_yin = 0; n_clr = 0; n_b = 0; n_w1 = 0; n_w2 = 0;
        bad_seq = 0; bad_addr = 0; phase = 0; p_b = 0; p_w1 = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (init_regs) begin
                    init_cyc = cyc;
                    n_yin = 0; n_clr = 0; n_b = 0; n_w1 = 0; n_w2 = 0;
                    bad_seq = 0; bad_addr = 0; phase = 0;
                end
                if (ld_yin) begin
                    n_yin++;
                    if (acc_clr) begin
                        n_clr++;
                        if (sel_term != SEL_B || phase != 0) bad_seq++;
                        phase = 1;
                    end else if (phase == 1 && sel_term == SEL_W1) begin
                        phase = 2;
                    end else if (phase == 2 && sel_term == SEL_W2) begin
                        phase = 0;
                    end else begin
                        bad_seq++;
                    end
                end else if (acc_clr) begin
                    bad_seq++;
                end
                if (ld_b)  n_b++;
                if (ld_w1) n_w1++;
                if (ld_w2) n_w2++;
                if ((ld_w1 != p_b) || (ld_w2 != p_w1)) bad_seq++;
                if ((int'(ld_b) + int'(ld_w1) + int'(ld_w2) + int'(ld_yin) +
                     int'(init_regs) + int'(done) + int'(ready)) > 1) bad_seq++;
                if (int'(addr) > N_SAMPLES - 1) bad_addr++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("latency",   cyc - init_cyc, e.lat);
                        check("converged", int'(converged), e.conv);
                        check("epoch",     int'(epoch), e.epochs);
                        check("ld_yin_cnt", n_yin, 3 * e.n_smp);
                        check("acc_clr_cnt", n_clr, e.n_smp);
                        check("ld_b_cnt",  n_b,  e.n_upd);
                        check("ld_w1_cnt", n_w1, e.n_upd);
                        check("ld_w2_cnt", n_w2, e.n_upd);
                        check("strobe_seq", bad_seq, 0);
                        check("addr_range", bad_addr, 0);
                    end
                end
                p_b  = ld_b;
                p_w1 = ld_w1;
            end else begin
                p_b  = 1'b0;
                p_w1 = 1'b0;
            end
        end
    end

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT, required event not seen", name);
    endtask

    // One run with spurious start pulses sprinkled while busy.
    task automatic run_one();
        exp_t e;
        int   guard;
        e = model();
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_after_start", int'(init_regs), 1);
        check("ready_drops", int'(ready), 0);
        guard = 0;
        while (!done && guard < 2000) begin
            start = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (!done) timeout("run_done");
        @(negedge clk);
        check("ready_after_done", int'(ready), 1);
        check("hold_converged", int'(converged), e.conv);
        check("hold_epoch", int'(epoch), e.epochs);
    endtask

    initial begin : main
        int d;
        int guard;
        int w2_seen;
        rst   = 1'b1;
        start = 1'b0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_strobes", int'({init_regs, acc_clr, ld_yin, ld_b, ld_w1, ld_w2, done}), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_epoch", int'(epoch), 0);
        check("rst_converged", int'(converged), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Clean first epoch.
        fill(0, 0);
        run_one();

        // Single mismatch at sample 2 of the first epoch.
        fill(0, 0);
        tbl[0][2] = 1'b1;
        run_one();

        // Every sample mismatches: run ends at the epoch limit.
        fill(1, 0);
        run_one();

        // Random mismatch patterns and densities.
        for (int r = 0; r < 25; r++) begin
            fill(2, $urandom_range(0, 5));
            run_one();
        end

        // start held high: retrigger two cycles after done.
        fill(0, 0);
        sb_q.push_back(model());
        sb_q.push_back(model());
        start = 1'b1;
        guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!done) timeout("held_done");
        d = cyc;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!init_regs && guard < 10);
        check("reinit_gap", cyc - d, 2);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!done) timeout("held_done2");
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        // Reset during UPD_W1 abandons the update sequence.
        mon_en = 1'b0;
        fill(1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!ld_w1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ld_w1) timeout("reach_upd_w1");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(ready), 1);
        check("midrst_strobes", int'({init_regs, acc_clr, ld_yin, ld_b, ld_w1, ld_w2, done}), 0);
        check("midrst_epoch", int'(epoch), 0);
        rst = 1'b0;
        w2_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ld_w2 || !ready) w2_seen++;
            @(negedge clk);
        end
        check("midrst_no_resume", w2_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_neuron_train_sequencer
`default_nettype wire
